// File: rtl/decode_execute_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_latch_if
// Description : Decode-to-execute bus. It carries the decode-stage operands and
//               control into the latch. It carries the latched execute-stage
//               fields and the decode stall back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_execute_latch_if #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5
);
    // decode side
    logic [WORD_W-1:0] rdat1_dec;
    logic [WORD_W-1:0] rdat2_dec;
    logic [1:0]        forwardA;
    logic [1:0]        forwardB;
    logic [WORD_W-1:0] ex_result;
    logic [WORD_W-1:0] mem_result;
    logic [REG_AW-1:0] Rs_dec;
    logic [REG_AW-1:0] Rt_dec;
    logic [REG_AW-1:0] Rd_dec;
    logic              uses_rt_dec;
    logic              valid_dec;
    logic              regWEN_dec;
    logic              memread_dec;
    logic              memwrite_dec;
    logic [WORD_W-1:0] imm_dec;
    logic [WORD_W-1:0] pc_dec;
    logic              ex_en;
    logic              flush;
    // execute side
    logic [WORD_W-1:0] opA_ex;
    logic [WORD_W-1:0] opB_ex;
    logic [WORD_W-1:0] imm_ex;
    logic [WORD_W-1:0] pc_ex;
    logic [REG_AW-1:0] Rd_ex;
    logic              regWEN_ex;
    logic              memread_ex;
    logic              memwrite_ex;
    logic              valid_ex;
    logic              stall_dec;

    modport master (
        output rdat1_dec, rdat2_dec, forwardA, forwardB, ex_result, mem_result,
               Rs_dec, Rt_dec, Rd_dec, uses_rt_dec, valid_dec, regWEN_dec,
               memread_dec, memwrite_dec, imm_dec, pc_dec, ex_en, flush,
        input  opA_ex, opB_ex, imm_ex, pc_ex, Rd_ex, regWEN_ex, memread_ex,
               memwrite_ex, valid_ex, stall_dec
    );

    modport slave (
        input  rdat1_dec, rdat2_dec, forwardA, forwardB, ex_result, mem_result,
               Rs_dec, Rt_dec, Rd_dec, uses_rt_dec, valid_dec, regWEN_dec,
               memread_dec, memwrite_dec, imm_dec, pc_dec, ex_en, flush,
        output opA_ex, opB_ex, imm_ex, pc_ex, Rd_ex, regWEN_ex, memread_ex,
               memwrite_ex, valid_ex, stall_dec
    );
endinterface
`default_nettype wire

// File: rtl/decode_execute_latch.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_latch
// Description : Decode/execute pipeline register. It applies the operand
//               forwarding and detects load-use hazards (one bubble plus a
//               decode stall). It also counts the bubbles it inserts.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_latch #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    decode_execute_latch_if.slave  bus,
    output logic [CNT_W-1:0]       bubble_cnt
);
    logic [WORD_W-1:0] w_fwd_a;
    logic [WORD_W-1:0] w_fwd_b;
    logic              w_hazard;
    logic              w_valid_gate;

    logic [WORD_W-1:0] r_opa;
    logic [WORD_W-1:0] r_opb;
    logic [WORD_W-1:0] r_imm;
    logic [WORD_W-1:0] r_pc;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwen;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // Operand forwarding: 01 takes memory/writeback, 10 takes execute, else regfile
    always_comb begin
        w_fwd_a = bus.rdat1_dec;
        w_fwd_b = bus.rdat2_dec;
        case (bus.forwardA)
            2'b01:   w_fwd_a = bus.mem_result;
            2'b10:   w_fwd_a = bus.ex_result;
            default: w_fwd_a = bus.rdat1_dec;
        endcase
        case (bus.forwardB)
            2'b01:   w_fwd_b = bus.mem_result;
            2'b10:   w_fwd_b = bus.ex_result;
            default: w_fwd_b = bus.rdat2_dec;
        endcase
    end

    // Load in execute whose destination the decode instruction reads; r0 is never a hazard
    assign w_hazard = r_valid & r_memread & (r_rd != '0) & bus.valid_dec &
                      ((r_rd == bus.Rs_dec) | (bus.uses_rt_dec & (r_rd == bus.Rt_dec)));

    // Control flags of a non-instruction must never take effect downstream
    assign w_valid_gate = bus.valid_dec;

    // Pipeline register: flush beats stall, stall beats hazard bubble, else capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_opa        <= '0;
            r_opb        <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_rd         <= '0;
            r_regwen     <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (bus.flush || (bus.ex_en && w_hazard)) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_regwen   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_valid    <= 1'b0;
            // only a hazard bubble is counted, and the counter sticks at all-ones
            if (!bus.flush && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (bus.ex_en) begin
            r_opa      <= w_fwd_a;
            r_opb      <= w_fwd_b;
            r_imm      <= bus.imm_dec;
            r_pc       <= bus.pc_dec;
            r_rd       <= bus.Rd_dec;
            r_regwen   <= bus.regWEN_dec   & w_valid_gate;
            r_memread  <= bus.memread_dec  & w_valid_gate;
            r_memwrite <= bus.memwrite_dec & w_valid_gate;
            r_valid    <= bus.valid_dec;
        end
    end

    assign bus.opA_ex      = r_opa;
    assign bus.opB_ex      = r_opb;
    assign bus.imm_ex      = r_imm;
    assign bus.pc_ex       = r_pc;
    assign bus.Rd_ex       = r_rd;
    assign bus.regWEN_ex   = r_regwen;
    assign bus.memread_ex  = r_memread;
    assign bus.memwrite_ex = r_memwrite;
    assign bus.valid_ex    = r_valid;
    assign bus.stall_dec   = w_hazard | ~bus.ex_en;
    assign bubble_cnt      = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_execute_latch
// Description : Self-checking bench for decode_execute_latch. A wide-counter
//               instance and a 2-bit-counter instance share one stimulus.
//               Both are compared against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_execute_latch;
    localparam int WORD_W = 32;
    localparam int REG_AW = 5;

    logic        CLK;
    logic        RST;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    decode_execute_latch_if #(.WORD_W(WORD_W), .REG_AW(REG_AW)) ifa ();
    decode_execute_latch_if #(.WORD_W(WORD_W), .REG_AW(REG_AW)) ifb ();

    decode_execute_latch #(.WORD_W(WORD_W), .REG_AW(REG_AW), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .bus(ifa.slave), .bubble_cnt(cnt16));

    decode_execute_latch #(.WORD_W(WORD_W), .REG_AW(REG_AW), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .bus(ifb.slave), .bubble_cnt(cnt2));

    // second instance mirrors the first one's inputs
    assign ifb.rdat1_dec    = ifa.rdat1_dec;
    assign ifb.rdat2_dec    = ifa.rdat2_dec;
    assign ifb.forwardA     = ifa.forwardA;
    assign ifb.forwardB     = ifa.forwardB;
    assign ifb.ex_result    = ifa.ex_result;
    assign ifb.mem_result   = ifa.mem_result;
    assign ifb.Rs_dec       = ifa.Rs_dec;
    assign ifb.Rt_dec       = ifa.Rt_dec;
    assign ifb.Rd_dec       = ifa.Rd_dec;
    assign ifb.uses_rt_dec  = ifa.uses_rt_dec;
    assign ifb.valid_dec    = ifa.valid_dec;
    assign ifb.regWEN_dec   = ifa.regWEN_dec;
    assign ifb.memread_dec  = ifa.memread_dec;
    assign ifb.memwrite_dec = ifa.memwrite_dec;
    assign ifb.imm_dec      = ifa.imm_dec;
    assign ifb.pc_dec       = ifa.pc_dec;
    assign ifb.ex_en        = ifa.ex_en;
    assign ifb.flush        = ifa.flush;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- instruction-level reference model ----------------
    // Contents of the execute slot, plus an unbounded count of hazard bubbles.
    logic              m_valid, m_we, m_mr, m_mw;
    logic [REG_AW-1:0] m_rd;
    logic [WORD_W-1:0] m_a, m_b, m_imm, m_pc;
    int                m_bubbles;

    function automatic logic [WORD_W-1:0] pick(input logic [1:0] sel, input logic [WORD_W-1:0] rf);
        if (sel == 2'd1) return ifa.mem_result;
        if (sel == 2'd2) return ifa.ex_result;
        return rf;
    endfunction

    function automatic logic m_hazard();
        logic reads_it;
        reads_it = (m_rd == ifa.Rs_dec) || (ifa.uses_rt_dec && m_rd == ifa.Rt_dec);
        return m_valid && m_mr && (m_rd != 0) && ifa.valid_dec && reads_it;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST || ifa.flush || (ifa.ex_en && m_hazard())) begin
            m_valid <= 0; m_we <= 0; m_mr <= 0; m_mw <= 0; m_rd <= 0;
            m_a <= 0; m_b <= 0; m_imm <= 0; m_pc <= 0;
            if (RST) m_bubbles <= 0;
            else if (!ifa.flush) m_bubbles <= m_bubbles + 1;
        end else if (ifa.ex_en) begin
            m_valid <= ifa.valid_dec;
            m_we    <= ifa.valid_dec && ifa.regWEN_dec;
            m_mr    <= ifa.valid_dec && ifa.memread_dec;
            m_mw    <= ifa.valid_dec && ifa.memwrite_dec;
            m_rd    <= ifa.Rd_dec;
            m_a     <= pick(ifa.forwardA, ifa.rdat1_dec);
            m_b     <= pick(ifa.forwardB, ifa.rdat2_dec);
            m_imm   <= ifa.imm_dec;
            m_pc    <= ifa.pc_dec;
        end
    end

    // Compare every cycle, midway between edges
    always @(negedge CLK) begin
        chk("valid_ex",    ifa.valid_ex,    m_valid);
        chk("regWEN_ex",   ifa.regWEN_ex,   m_we);
        chk("memread_ex",  ifa.memread_ex,  m_mr);
        chk("memwrite_ex", ifa.memwrite_ex, m_mw);
        chk("Rd_ex",       ifa.Rd_ex,       m_rd);
        chk("opA_ex",      ifa.opA_ex,      m_a);
        chk("opB_ex",      ifa.opB_ex,      m_b);
        chk("imm_ex",      ifa.imm_ex,      m_imm);
        chk("pc_ex",       ifa.pc_ex,       m_pc);
        chk("stall_dec",   ifa.stall_dec,   m_hazard() || !ifa.ex_en);
        chk("bubble_cnt",  cnt16, (m_bubbles > 65535) ? 64'd65535 : 64'(m_bubbles));
        chk("bubble_cnt_sat", cnt2, (m_bubbles > 3) ? 64'd3 : 64'(m_bubbles));
        chk("valid_ex_sat", ifb.valid_ex,   m_valid);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ifa.rdat1_dec = 0; ifa.rdat2_dec = 0; ifa.forwardA = 0; ifa.forwardB = 0;
        ifa.ex_result = 0; ifa.mem_result = 0; ifa.Rs_dec = 0; ifa.Rt_dec = 0;
        ifa.Rd_dec = 0; ifa.uses_rt_dec = 0; ifa.valid_dec = 0; ifa.regWEN_dec = 0;
        ifa.memread_dec = 0; ifa.memwrite_dec = 0; ifa.imm_dec = 0; ifa.pc_dec = 0;
        ifa.ex_en = 1; ifa.flush = 0;
    endtask

    task automatic load_r8();
        ifa.valid_dec = 1; ifa.regWEN_dec = 1; ifa.memread_dec = 1;
        ifa.Rd_dec = 8; ifa.Rs_dec = 1; ifa.uses_rt_dec = 0; ifa.forwardA = 0;
    endtask

    task automatic rand_inputs();
        ifa.rdat1_dec = $urandom; ifa.rdat2_dec = $urandom;
        ifa.ex_result = $urandom; ifa.mem_result = $urandom;
        ifa.imm_dec = $urandom; ifa.pc_dec = $urandom;
        ifa.forwardA = 2'($urandom_range(0, 3));
        ifa.forwardB = 2'($urandom_range(0, 3));
        ifa.Rs_dec = 5'($urandom_range(0, 3));
        ifa.Rt_dec = 5'($urandom_range(0, 3));
        ifa.Rd_dec = 5'($urandom_range(0, 3));
        ifa.uses_rt_dec  = 1'($urandom_range(0, 1));
        ifa.valid_dec    = ($urandom_range(0, 3) != 0);
        ifa.regWEN_dec   = 1'($urandom_range(0, 1));
        ifa.memread_dec  = ($urandom_range(0, 2) == 0);
        ifa.memwrite_dec = 1'($urandom_range(0, 1));
        ifa.ex_en        = ($urandom_range(0, 9) != 0);
        ifa.flush        = ($urandom_range(0, 11) == 0);
    endtask

    initial begin
        idle();
        RST = 1;
        tick(); tick();
        chk("reset valid_ex", ifa.valid_ex, 0);
        chk("reset bubble_cnt", cnt16, 0);
        chk("reset opA_ex", ifa.opA_ex, 0);
        RST = 0;

        // forwarding selects
        ifa.rdat1_dec = 32'h11; ifa.rdat2_dec = 32'h44;
        ifa.ex_result = 32'h22; ifa.mem_result = 32'h33;
        ifa.forwardA = 2'b10; ifa.forwardB = 2'b01; ifa.valid_dec = 1;
        tick();
        chk("fwd opA ex_result", ifa.opA_ex, 32'h22);
        chk("fwd opB mem_result", ifa.opB_ex, 32'h33);
        ifa.forwardA = 2'b11;
        tick();
        chk("fwd opA 11 regfile", ifa.opA_ex, 32'h11);

        // load-use hazard, one bubble, then capture with forwarding from memory
        idle(); ifa.rdat1_dec = 32'h11; ifa.mem_result = 32'h33;
        load_r8();
        tick();
        ifa.memread_dec = 0; ifa.Rd_dec = 9; ifa.Rs_dec = 8;
        #1 chk("load-use stall", ifa.stall_dec, 1);
        tick();
        chk("load-use bubble valid", ifa.valid_ex, 0);
        chk("load-use bubble_cnt", cnt16, 1);
        ifa.forwardA = 2'b01;
        #1 chk("after bubble stall", ifa.stall_dec, 0);
        tick();
        chk("after bubble valid", ifa.valid_ex, 1);
        chk("after bubble opA", ifa.opA_ex, 32'h33);
        chk("after bubble Rd", ifa.Rd_ex, 9);

        // Rt not read -> no hazard
        load_r8();
        tick();
        ifa.memread_dec = 0; ifa.Rd_dec = 9; ifa.Rs_dec = 2; ifa.Rt_dec = 8; ifa.uses_rt_dec = 0;
        #1 chk("unused Rt stall", ifa.stall_dec, 0);
        tick();
        chk("unused Rt valid", ifa.valid_ex, 1);
        chk("unused Rt cnt", cnt16, 1);
        // load to r0 -> no hazard
        ifa.memread_dec = 1; ifa.Rd_dec = 0;
        tick();
        ifa.memread_dec = 0; ifa.Rd_dec = 9; ifa.Rs_dec = 0; ifa.Rt_dec = 0;
        #1 chk("Rd0 stall", ifa.stall_dec, 0);
        tick();
        chk("Rd0 cnt", cnt16, 1);

        // downstream stall holds, then flush overrides it
        ifa.regWEN_dec = 1; ifa.Rd_dec = 5; ifa.pc_dec = 32'h100; ifa.Rs_dec = 1;
        tick();
        ifa.ex_en = 0; ifa.pc_dec = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ex_en stall", ifa.stall_dec, 1);
            tick();
            chk("hold pc_ex", ifa.pc_ex, 32'h100);
        end
        ifa.flush = 1;
        tick();
        chk("flush valid", ifa.valid_ex, 0);
        chk("flush regWEN", ifa.regWEN_ex, 0);
        chk("flush pc", ifa.pc_ex, 0);
        ifa.flush = 0; ifa.ex_en = 1;

        // flush together with hazard: no count
        load_r8();
        tick();
        ifa.memread_dec = 0; ifa.Rd_dec = 9; ifa.Rs_dec = 8; ifa.flush = 1;
        #1 chk("flush+hazard stall", ifa.stall_dec, 1);
        tick();
        chk("flush+hazard cnt", cnt16, 1);
        ifa.flush = 0;

        // four more hazards: five in total, 2-bit counter saturates
        for (int i = 0; i < 4; i++) begin
            load_r8();
            tick();
            ifa.memread_dec = 0; ifa.Rd_dec = 9; ifa.Rs_dec = 8;
            tick();
        end
        chk("five hazards cnt", cnt16, 5);
        chk("saturated cnt", cnt2, 3);

        // asynchronous reset between edges
        ifa.Rs_dec = 1; ifa.Rd_dec = 5; ifa.regWEN_dec = 1; ifa.valid_dec = 1;
        tick();
        chk("pre-reset valid", ifa.valid_ex, 1);
        chk("pre-reset regWEN", ifa.regWEN_ex, 1);
        chk("pre-reset cnt", cnt16, 5);
        #1 RST = 1;
        #1;
        chk("async reset valid", ifa.valid_ex, 0);
        chk("async reset regWEN", ifa.regWEN_ex, 0);
        chk("async reset cnt", cnt16, 0);
        chk("async reset cnt_sat", cnt2, 0);
        chk("async reset pc", ifa.pc_ex, 0);
        tick();
        RST = 0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_execute_latch.md
Name: decode_execute_latch

Overview:
- Pipeline register between the decode stage and the execute stage.
- Applies the decode-stage operand-forwarding selects (forwardA/forwardB) to the register-file read data, then latches the operands and control into execute.
- Detects load-use hazards against the instruction currently in execute, inserts one bubble, and stalls decode.
- Exports the registered execute-stage destination and write-enable that the forwarding logic compares against.

Parameters:
WORD_W, 32, datapath word width
REG_AW, 5, register address width
CNT_W, 16, bubble performance counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
rdat1_dec  in  WORD_W  register file port A data (Rs)
rdat2_dec  in  WORD_W  register file port B data (Rt)
forwardA  in  2  operand A select: 00 regfile, 01 mem result, 10 ex result, 11 regfile
forwardB  in  2  operand B select, same encoding as forwardA
ex_result  in  WORD_W  result produced in execute this cycle
mem_result  in  WORD_W  result in memory/writeback this cycle
Rs_dec  in  REG_AW  decode source register A
Rt_dec  in  REG_AW  decode source register B
Rd_dec  in  REG_AW  decode destination register
uses_rt_dec  in  1  decode instruction reads Rt
valid_dec  in  1  decode holds a real instruction
regWEN_dec  in  1  decode write-enable
memread_dec  in  1  decode is a load
memwrite_dec  in  1  decode is a store
imm_dec  in  WORD_W  extended immediate
pc_dec  in  WORD_W  instruction PC
ex_en  in  1  execute may accept (0 = downstream stall)
flush  in  1  squash the execute-stage contents (branch/jump redirect)
opA_ex  out  WORD_W  latched operand A
opB_ex  out  WORD_W  latched operand B
imm_ex  out  WORD_W  latched immediate
pc_ex  out  WORD_W  latched PC
Rd_ex  out  REG_AW  latched destination; feeds the forwarding logic
regWEN_ex  out  1  latched write-enable; feeds the forwarding logic
memread_ex  out  1  latched load flag
memwrite_ex  out  1  latched store flag
valid_ex  out  1  execute holds a real instruction
stall_dec  out  1  combinational: decode and fetch must hold
bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (RST=1, asynchronous): all registered outputs are 0, including bubble_cnt. stall_dec is still driven combinationally from the (zeroed) registers and inputs.
- Operand mux (combinational):
  - fwdA = mem_result if forwardA=01; ex_result if 10; else rdat1_dec.
  - fwdB is selected the same way from forwardB and rdat2_dec.
- hazard (combinational) = valid_ex & memread_ex & (Rd_ex!=0) & valid_dec & ((Rd_ex==Rs_dec) | (uses_rt_dec & Rd_ex==Rt_dec)).
- stall_dec = hazard | !ex_en.
- Rising-edge update, highest priority first:
  1. flush=1: load a bubble. Bubble = valid_ex, regWEN_ex, memread_ex, memwrite_ex, Rd_ex, opA_ex, opB_ex, imm_ex, pc_ex all 0. Flush overrides ex_en=0.
  2. ex_en=0: hold all registers.
  3. hazard=1: load a bubble; bubble_cnt += 1, saturating at all-ones.
  4. Otherwise capture: opA_ex<=fwdA, opB_ex<=fwdB, every other *_dec field into its *_ex register, valid_ex<=valid_dec.
- A captured invalid instruction (valid_dec=0) forces regWEN_ex, memread_ex and memwrite_ex to 0.
- Latency: exactly one cycle from decode to the *_ex outputs; one cycle of bubble per load-use hazard.
- After a bubble, the load has moved on to memory, so hazard deasserts. The held decode instruction then captures with forwardA/forwardB=01 supplied externally.
- Simultaneous flush and hazard: the flush bubble is loaded and bubble_cnt does not increment. stall_dec still reflects hazard that cycle.
- Rd_ex=0 never triggers a hazard.

Test Plan:
- Reset mid-run: assert RST asynchronously between clock edges while valid_ex=1, regWEN_ex=1, bubble_cnt=5 -> all outputs 0 immediately, without waiting for a clock edge.
- Forward select: rdat1_dec=0x11, ex_result=0x22, mem_result=0x33, forwardA=10, forwardB=01, valid_dec=1, ex_en=1 -> after one edge opA_ex=0x22, opB_ex=0x33. Repeat with forwardA=11 -> opA_ex=0x11.
- Load-use: load with Rd=8 in execute (memread_ex=1); decode has Rs_dec=8 -> stall_dec=1, next edge valid_ex=0, bubble_cnt=1. Following edge: decode instruction captured with forwardA=01, opA_ex=mem_result.
- Hazard ignored: same as load-use but Rt_dec=8 with uses_rt_dec=0, or Rd_ex=0 -> stall_dec=0, no bubble, bubble_cnt unchanged.
- Stall/flush priority: ex_en=0 for 3 cycles -> *_ex held, stall_dec=1. Then flush=1 with ex_en=0 -> next edge bubble loaded, valid_ex=0, regWEN_ex=0.
- Counter saturation: CNT_W=2, provoke 5 load-use hazards -> bubble_cnt reads 3 and stays 3.
